// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the time-multiplexed FIR filter (fir_seq / fir_mac).
//   - fir_state_e : controller states IDLE / MAC / ROUND / OUT (2-bit)
//   - FIR_*       : default widths and tap count
//   - sat()       : clamp a signed value into a w-bit signed range; only used
//                   when the design is built with FIR_SAT_EN defined
package fir_pkg;

    localparam int FIR_DATA_W    = 16;
    localparam int FIR_COEF_W    = 16;
    localparam int FIR_TAPS      = 11;
    localparam int FIR_ACC_W     = 40;
    localparam int FIR_OUT_SHIFT = 15;

    // Working width of the saturation helper; ACC_W must not exceed it.
    localparam int FIR_SAT_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    // Clamp s to [-2^(w-1), 2^(w-1)-1]; the caller keeps the low w bits.
    function automatic logic signed [FIR_SAT_W-1:0] sat(
        input logic signed [FIR_SAT_W-1:0] s,
        input int unsigned                 w
    );
        logic signed [FIR_SAT_W-1:0] max_pos;
        logic signed [FIR_SAT_W-1:0] min_neg;
        max_pos = $signed((FIR_SAT_W'(1) << (w - 1)) - FIR_SAT_W'(1));
        min_neg = -max_pos - FIR_SAT_W'(1);
        if (s > max_pos) begin
            return max_pos;
        end else if (s < min_neg) begin
            return min_neg;
        end
        return s;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac
// Arithmetic datapath of the FIR filter: one signed multiply per cycle, an
// ACC_W wrapping accumulator, and the output shift stage that forms y.
// Build option: FIR_SAT_EN selects saturation of the shifted accumulator;
// without it y is the wrapped bit slice acc[OUT_SHIFT +: DATA_W].
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   acc_clr           zero the accumulator (has priority over acc_en)
//   acc_en            add sample*coef into the accumulator
//   y_load            register the shifted accumulator into y
//   sample, coef      signed multiplier operands
//   y                 registered filter output
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W    = FIR_DATA_W,
    parameter int COEF_W    = FIR_COEF_W,
    parameter int ACC_W     = FIR_ACC_W,
    parameter int OUT_SHIFT = FIR_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     acc_clr,
    input  logic                     acc_en,
    input  logic                     y_load,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic        [DATA_W-1:0] y
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [DATA_W-1:0] y_q, y_d;
    logic        [DATA_W-1:0] y_round;

    // Full-precision signed product, sign-extended into the accumulator width.
    assign product     = sample * coef;
    assign product_ext = ACC_W'(product);

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_q >>> OUT_SHIFT;
    assign y_round = DATA_W'(sat(FIR_SAT_W'(shifted), DATA_W));
`else
    assign y_round = acc_q[OUT_SHIFT +: DATA_W];
`endif

    // The accumulator wraps modulo 2^ACC_W; it is never saturated internally.
    always_comb begin
        acc_d = acc_q;
        y_d   = y_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + product_ext;
        end
        if (y_load) begin
            y_d = y_round;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/fir_seq.sv
// fir_seq
// Time-multiplexed direct-form FIR filter with a run-time writable
// coefficient bank and valid/ready handshakes on input and output.
// One sample is processed in TAPS MAC cycles, one ROUND cycle, then the
// result is held in OUT until downstream takes it.
// Build option: FIR_SAT_EN (saturating output stage, see fir_mac).
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   x, in_valid, in_ready sample input handshake (in_ready only high in IDLE)
//   y, out_valid, out_ready filtered output handshake
//   coef_we, coef_addr, coef_data  coefficient write port (IDLE only)
//   clr                   synchronous delay-line flush (IDLE only, beats in_valid)
module fir_seq
    import fir_pkg::*;
#(
    parameter int   DATA_W    = FIR_DATA_W,
    parameter int   COEF_W    = FIR_COEF_W,
    parameter int   TAPS      = FIR_TAPS,
    parameter int   ACC_W     = FIR_ACC_W,
    parameter int   OUT_SHIFT = FIR_OUT_SHIFT,
    localparam int  ADDR_W    = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] x,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              clr
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);

    fir_state_e               state_q, state_d;
    logic        [ADDR_W-1:0] k_q, k_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] d_q [TAPS];
    logic signed [DATA_W-1:0] d_d [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [COEF_W-1:0] c_d [TAPS];

    logic acc_clr;
    logic acc_en;
    logic y_load;
    logic coef_wr_ok;

    // A flush request blocks acceptance in the same cycle.
    assign in_ready   = (state_q == IDLE) && !clr;
    assign coef_wr_ok = (state_q == IDLE) && coef_we && (int'(coef_addr) < TAPS);

    // Next-state, delay-line, coefficient-bank and datapath control.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;
        c_d         = c_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        y_load      = 1'b0;

        // Applied before the MAC pass starts, so a write in the accept cycle
        // is already visible to that sample.
        if (coef_wr_ok) begin
            c_d[coef_addr] = coef_data;
        end

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    for (int i = 0; i < TAPS; i++) begin
                        d_d[i] = '0;
                    end
                end else if (in_valid) begin
                    d_d[0] = $signed(x);
                    for (int i = 1; i < TAPS; i++) begin
                        d_d[i] = d_q[i-1];
                    end
                    acc_clr = 1'b1;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                // k returns to 0 after the last tap so the operand index
                // always stays inside the arrays.
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ROUND;
                end else begin
                    k_d = k_q + ADDR_W'(1);
                end
            end
            ROUND: begin
                y_load      = 1'b1;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;

    fir_mac #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .y_load  (y_load),
        .sample  (d_q[k_q]),
        .coef    (c_q[k_q]),
        .y       (y)
    );

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq
// Self-checking bench for fir_seq. A behavioural model (sample history,
// coefficient table, plain 64-bit arithmetic) predicts in_ready, out_valid
// and y for every cycle; directed scenarios add literal expectations.
// Honours FIR_SAT_EN the same way as the design.
module tb_fir_seq;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int TAPS      = 11;
    localparam int ACC_W     = 40;
    localparam int OUT_SHIFT = 15;
    localparam int ADDR_W    = $clog2(TAPS);

`ifdef FIR_SAT_EN
    localparam longint SAT_MAX = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint SAT_MIN = -SAT_MAX - 1;
`endif

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic [DATA_W-1:0] x         = '0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic              coef_we   = 1'b0;
    logic [ADDR_W-1:0] coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              clr       = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] y;

    int tests = 0;
    int fails = 0;

    // Model state
    logic signed [DATA_W-1:0] hist_m [TAPS] = '{default: '0};
    logic signed [COEF_W-1:0] coef_m [TAPS] = '{default: '0};
    bit                       m_idle = 1'b1;
    bit                       exp_ov = 1'b0;
    logic [DATA_W-1:0]        exp_y  = '0;
    logic [DATA_W-1:0]        pend_y = '0;
    int                       cnt    = 0;

    fir_seq #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clr       (clr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Filter output from the sample history: sum of products, wrap to ACC_W,
    // arithmetic shift, then wrap or clamp into DATA_W.
    function automatic logic [DATA_W-1:0] modelY();
        longint sum = 0;
        longint s;
        for (int k = 0; k < TAPS; k++) begin
            sum += longint'(hist_m[k]) * longint'(coef_m[k]);
        end
        sum = (sum <<< (64 - ACC_W)) >>> (64 - ACC_W);
        s   = sum >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
`endif
        return DATA_W'(s);
    endfunction

    // Transaction-level model: an accepted sample produces its result
    // TAPS+1 edges later and holds it until out_ready is seen.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            hist_m = '{default: '0};
            coef_m = '{default: '0};
            m_idle = 1'b1;
            exp_ov = 1'b0;
            exp_y  = '0;
            cnt    = 0;
        end else if (m_idle) begin
            if (coef_we && int'(coef_addr) < TAPS) begin
                coef_m[coef_addr] = coef_data;
            end
            if (clr) begin
                hist_m = '{default: '0};
            end else if (in_valid) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    hist_m[i] = hist_m[i-1];
                end
                hist_m[0] = x;
                pend_y    = modelY();
                m_idle    = 1'b0;
                cnt       = 0;
            end
        end else if (!exp_ov) begin
            cnt++;
            if (cnt == TAPS + 1) begin
                exp_ov = 1'b1;
                exp_y  = pend_y;
            end
        end else if (out_ready) begin
            exp_ov = 1'b0;
            m_idle = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        checkOutput("in_ready", 64'(in_ready), 64'(m_idle && !clr));
        checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            checkOutput("y", 64'(y), 64'(exp_y));
        end
    end

    // Drive one cycle of inputs; entered and left just after a rising edge.
    task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] xv,
                                 input logic cw, input logic [ADDR_W-1:0] ca,
                                 input logic [COEF_W-1:0] cd, input logic cl,
                                 input logic ordy);
        in_valid  = iv;
        x         = xv;
        coef_we   = cw;
        coef_addr = ca;
        coef_data = cd;
        clr       = cl;
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input logic [COEF_W-1:0] value);
        applyStimulus(1'b0, '0, 1'b1, ADDR_W'(addr), value, 1'b0, out_ready);
    endtask

    task automatic sendSample(input logic [DATA_W-1:0] xv);
        int waited = 0;
        in_valid = 1'b1;
        x        = xv;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Returns the number of edges from the accept edge until out_valid is seen.
    task automatic waitOutput(output logic [DATA_W-1:0] yv, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            if (lat > 200) begin
                tests++;
                fails++;
                $display("[TB] FAIL output_timeout: out_valid stayed 0, required 1");
                break;
            end
        end
        yv = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] yv;
        int                lat;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_y", 64'(y), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Impulse response
        for (int k = 0; k < TAPS; k++) begin
            writeCoef(k, COEF_W'(16'h0100 * (k + 1)));
        end
        for (int n = 0; n < TAPS; n++) begin
            sendSample((n == 0) ? 16'h4000 : 16'h0000);
            waitOutput(yv, lat);
            checkOutput("impulse_y", 64'(yv), 64'(128 * (n + 1)));
            checkOutput("impulse_latency", 64'(lat), 64'd12);
        end

        // Backpressure
        out_ready = 1'b0;
        sendSample(16'h1357);
        waitOutput(yv, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_y", 64'(y), 64'(exp_y));
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a MAC pass
        sendSample(16'h1234);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_y", 64'(y), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sendSample(16'h4000);
        waitOutput(yv, lat);
        checkOutput("post_reset_y", 64'(yv), 64'd0);

        // Coefficient write during MAC is ignored; in IDLE it takes effect
        writeCoef(0, 16'h1000);
        sendSample(16'h2000);
        repeat (3) @(posedge clk);
        #1;
        writeCoef(0, 16'h7FFF);
        waitOutput(yv, lat);
        checkOutput("mac_write_ignored_y", 64'(yv), 64'd1024);
        writeCoef(0, 16'h7FFF);
        sendSample(16'h2000);
        waitOutput(yv, lat);
        checkOutput("idle_write_y", 64'(yv), 64'd8191);

        // Saturation / wrap on a full delay line
        for (int k = 0; k < TAPS; k++) begin
            writeCoef(k, 16'h7FFF);
        end
        for (int n = 0; n < TAPS; n++) begin
            sendSample(16'h7FFF);
            waitOutput(yv, lat);
        end
`ifdef FIR_SAT_EN
        checkOutput("sat_y", 64'(yv), 64'h7FFF);
`else
        checkOutput("wrap_y", 64'(yv), 64'h7FEA);
`endif

        // Flush, with clr beating a simultaneous in_valid
        sendSample(16'h1111);
        waitOutput(yv, lat);
        sendSample(16'h2222);
        waitOutput(yv, lat);
        sendSample(16'h3333);
        waitOutput(yv, lat);
        clr      = 1'b1;
        in_valid = 1'b1;
        x        = 16'h5555;
        @(negedge clk);
        checkOutput("clr_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        sendSample(16'h0000);
        waitOutput(yv, lat);
        checkOutput("flush_y", 64'(yv), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom),
                          ($urandom_range(0, 3) == 0), ADDR_W'($urandom),
                          COEF_W'($urandom), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_seq.md
# fir_seq

Parametrised, time-multiplexed direct-form FIR filter. It replaces the fixed 11-tap block with a design that is generic in data width, coefficient width and tap count, and has a run-time-writable coefficient bank. It uses one signed multiply-accumulate per cycle and has valid/ready handshakes on both the sample input and the filtered output. It sits between the sample source and the downstream decimation/output logic in the DSP datapath.

## Interface
- DATA_W, 16: sample and output width, signed two's complement
- COEF_W, 16: coefficient width, signed
- TAPS, 11: number of taps, minimum 2
- ACC_W, 40: accumulator width, must be at least DATA_W+COEF_W+$clog2(TAPS)
- OUT_SHIFT, 15: right shift applied to the accumulator to form y (Q1.15 coefficients)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- x  in  DATA_W  input sample
- in_valid  in  1  x is valid
- in_ready  out  1  block can accept a sample
- y  out  DATA_W  filtered output
- out_valid  out  1  y is valid
- out_ready  in  1  downstream accepts y
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index
- coef_data  in  COEF_W  coefficient value
- clr  in  1  synchronous delay-line flush

## Operation
- State machine: IDLE, MAC, ROUND, OUT.
- IDLE:
  - in_ready=1.
  - When in_valid is high, the sample is accepted: d[0]<=x, d[k]<=d[k-1], acc<=0, k<=0, and the state moves to MAC.
  - If clr=1 with no in_valid, all d[] are set to 0.
  - If clr and in_valid are both high, clr wins and the sample is not accepted; in_ready is low in that cycle.
- MAC:
  - Each cycle, acc<=acc+sext(d[k]*c[k]) and k<=k+1.
  - After k=TAPS-1 the state moves to ROUND.
- ROUND:
  - Without FIR_SAT_EN: y<=acc[OUT_SHIFT+:DATA_W], which is truncation with wrap.
  - out_valid<=1 and the state moves to OUT.
- OUT:
  - y and out_valid are held stable until out_valid&&out_ready.
  - On that handshake, out_valid<=0 and the state moves to IDLE.
- Arithmetic: all products and the accumulator are signed. Products are sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W and is never saturated internally.
- Coefficient writes:
  - Accepted only in IDLE.
  - Ignored in MAC, ROUND and OUT, and ignored when coef_addr>=TAPS.
  - A write in the same IDLE cycle as a sample accept takes effect for that sample.
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, y=0.
  - acc=0, k=0.
  - all d[]=0 and all c[]=0.
- Reset mid-operation aborts the computation immediately and returns all state to the reset values; no partial output appears.

## Timing
- Accept edge = E0. The MAC adds occur on E1..E_TAPS. ROUND registers y on E_(TAPS+1).
- out_valid is high starting in the cycle after E_(TAPS+1), which is latency TAPS+1 edges.
- With out_ready held at 1, the handshake occurs on E_(TAPS+2). in_ready is high again after that edge, so the maximum rate is one sample per TAPS+3 cycles.
- in_ready is combinational from state (plus clr). It is never high outside IDLE.
- out_valid never drops without a handshake except on reset.

## Configuration
- FIR_SAT_EN defined:
  - ROUND computes s=acc>>>OUT_SHIFT (arithmetic shift).
  - If s>2^(DATA_W-1)-1, y=max positive. If s<-2^(DATA_W-1), y=min negative. Otherwise y=s[DATA_W-1:0].
- FIR_SAT_EN undefined: truncation/wrap as described in Operation. The saturation comparators are not synthesised.

## Structure
- fir_pkg holds:
  - the state enum (IDLE/MAC/ROUND/OUT, 2-bit)
  - localparams for default widths
  - a sat function used only under FIR_SAT_EN
- One sub-module: fir_mac. It holds the signed multiplier, the ACC_W accumulator and its clear/enable, and the output shift/saturate stage. fir_seq owns the FSM, the delay line, the coefficient bank and the handshakes.

## Test plan
- Impulse response:
  - Setup: load c[k]=16'h0100*(k+1) for k=0..10, then feed x=16'h4000 followed by 10 zeros, with out_ready=1.
  - Required: y=128,256,...,1408 (128*(k+1)), and out_valid rises exactly 12 edges after each accept.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises.
  - Required: y and out_valid stay stable and in_ready=0 throughout; after the handshake, in_ready=1 on the next cycle.
- Saturation:
  - Stimulus: all c=16'h7FFF, and 11 samples of x=16'h7FFF.
  - Required on the 11th output: y=16'h7FFF with FIR_SAT_EN defined, and y=16'h7FEA without it.
- Coefficient write during MAC:
  - Stimulus: write c[0]=16'h7FFF mid-computation.
  - Required: it is ignored, and the output matches the previous coefficients. The same write issued in IDLE takes effect on the next sample.
- Reset during MAC:
  - Stimulus: pulse reset_n low at E5.
  - Required: out_valid=0, y=0 and in_ready=1 immediately. A subsequent impulse sees an all-zero delay line and zero coefficients, giving y=0.
- Flush:
  - Stimulus: feed 3 nonzero samples, pulse clr in IDLE, then feed x=0 with nonzero coefficients.
  - Required: y=0.
